// File: rtl/vitals_tracker.sv
// Per-player health/guard tracker: hit and block detection from state codes,
// guard regeneration and break, KO, round end and draw detection.
module vitals_tracker #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned HP_W        = 3,
    parameter int unsigned MAX_HP      = 3,
    parameter int unsigned MAX_GUARD   = 3,
    parameter int unsigned HIT_DMG     = 1,
    parameter int unsigned S_HITSTUN   = 9,
    parameter int unsigned S_BLOCKSTUN = 10,
    parameter int unsigned REGEN_TICKS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic                           round_start,
    input  logic [NUM_PLAYERS*STATE_W-1:0] player_state,
    output logic [NUM_PLAYERS*HP_W-1:0]    health,
    output logic [NUM_PLAYERS*HP_W-1:0]    guard,
    output logic [NUM_PLAYERS-1:0]         guard_break,
    output logic [NUM_PLAYERS-1:0]         ko,
    output logic                           round_over,
    output logic                           draw
);

    localparam int unsigned CNT_W = (REGEN_TICKS > 1) ? $clog2(REGEN_TICKS) : 1;
    localparam logic [HP_W-1:0]    HP_RELOAD    = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0]    GUARD_RELOAD = HP_W'(MAX_GUARD);
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(REGEN_TICKS - 1);
    localparam logic [STATE_W-1:0] HIT_CODE     = STATE_W'(S_HITSTUN);
    localparam logic [STATE_W-1:0] BLK_CODE     = STATE_W'(S_BLOCKSTUN);

    logic [STATE_W-1:0] prev_state [NUM_PLAYERS];
    logic [STATE_W-1:0] cur_state  [NUM_PLAYERS];
    logic [HP_W-1:0]    hp_cur     [NUM_PLAYERS];
    logic [HP_W-1:0]    gd_cur     [NUM_PLAYERS];
    logic [CNT_W-1:0]   regen_cnt  [NUM_PLAYERS];
    logic               frozen;
    logic               active;

    logic [NUM_PLAYERS-1:0] hit_evt;
    logic [NUM_PLAYERS-1:0] blk_evt;

    logic [HP_W-1:0]        hp_nx  [NUM_PLAYERS];
    logic [HP_W-1:0]        gd_nx  [NUM_PLAYERS];
    logic [CNT_W-1:0]       cnt_nx [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] gb_nx;
    logic [NUM_PLAYERS-1:0] ko_nx;
    logic [NUM_PLAYERS-1:0] ko_new;
    logic                   round_over_nx;
    logic                   draw_nx;
    logic                   frozen_nx;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] v);
        if (32'(v) > HIT_DMG) return v - HP_W'(HIT_DMG);
        else                  return '0;
    endfunction

    // Events are ignored while frozen and in the reload cycle.
    assign active = !frozen && !round_start;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        assign cur_state[g] = player_state[g*STATE_W +: STATE_W];
        assign hp_cur[g]    = health[g*HP_W +: HP_W];
        assign gd_cur[g]    = guard[g*HP_W +: HP_W];
        assign hit_evt[g]   = active && (cur_state[g] != prev_state[g]) && (cur_state[g] == HIT_CODE);
        assign blk_evt[g]   = active && (cur_state[g] != prev_state[g]) && (cur_state[g] == BLK_CODE);
    end

    always_comb begin
        gb_nx = '0;
        ko_nx = ko;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            hp_nx[i]  = hp_cur[i];
            gd_nx[i]  = gd_cur[i];
            cnt_nx[i] = regen_cnt[i];

            if (hit_evt[i] || (blk_evt[i] && gd_cur[i] == '0)) begin
                hp_nx[i] = sat_sub(hp_cur[i]);
            end

            if (blk_evt[i]) begin
                if (gd_cur[i] == '0) begin
                    gd_nx[i] = GUARD_RELOAD;
                    gb_nx[i] = 1'b1;
                end else begin
                    gd_nx[i] = gd_cur[i] - HP_W'(1);
                end
            end

            // Regen counter: cleared by any event, parked at 0 while guard is full.
            if (hit_evt[i] || blk_evt[i] || gd_cur[i] >= GUARD_RELOAD) begin
                cnt_nx[i] = '0;
            end else if (tick && active) begin
                if (regen_cnt[i] == CNT_LAST) begin
                    gd_nx[i]  = gd_cur[i] + HP_W'(1);
                    cnt_nx[i] = '0;
                end else begin
                    cnt_nx[i] = regen_cnt[i] + CNT_W'(1);
                end
            end

            if (hp_nx[i] == '0) ko_nx[i] = 1'b1;
        end

        ko_new        = ko_nx & ~ko;
        round_over_nx = (ko == '0) && (ko_nx != '0);
        draw_nx       = draw || (round_over_nx && ((ko_new & (ko_new - NUM_PLAYERS'(1))) != '0));
        frozen_nx     = frozen || round_over_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                prev_state[i]          <= '0;
                regen_cnt[i]           <= '0;
                health[i*HP_W +: HP_W] <= HP_RELOAD;
                guard[i*HP_W +: HP_W]  <= GUARD_RELOAD;
            end
            guard_break <= '0;
            ko          <= '0;
            round_over  <= 1'b0;
            draw        <= 1'b0;
            frozen      <= 1'b0;
        end else if (round_start) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                prev_state[i]          <= cur_state[i];
                regen_cnt[i]           <= '0;
                health[i*HP_W +: HP_W] <= HP_RELOAD;
                guard[i*HP_W +: HP_W]  <= GUARD_RELOAD;
            end
            guard_break <= '0;
            ko          <= '0;
            round_over  <= 1'b0;
            draw        <= 1'b0;
            frozen      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                prev_state[i]          <= cur_state[i];
                regen_cnt[i]           <= cnt_nx[i];
                health[i*HP_W +: HP_W] <= hp_nx[i];
                guard[i*HP_W +: HP_W]  <= gd_nx[i];
            end
            guard_break <= gb_nx;
            ko          <= ko_nx;
            round_over  <= round_over_nx;
            draw        <= draw_nx;
            frozen      <= frozen_nx;
        end
    end

endmodule
